// File: rtl/echo_request_input.sv
// Echo request deserializer: parses framed 32-bit words from the portal pipe and
// issues one say/say2 call per well-formed frame. Malformed frames are drained and counted.
module echo_request_input (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pipe_enq_ena_i,
  input  logic [31:0] pipe_enq_v_i,
  output logic        pipe_enq_rdy_o,
  output logic        req_say_ena_o,
  output logic [31:0] req_say_meth_o,
  output logic [31:0] req_say_v_o,
  input  logic        req_say_rdy_i,
  output logic        req_say2_ena_o,
  output logic [31:0] req_say2_meth_o,
  output logic [31:0] req_say2_v_o,
  input  logic        req_say2_rdy_i,
  output logic [7:0]  error_count_o
);

  typedef enum logic [2:0] {
    StHdr,
    StArg0,
    StArg1,
    StDispatch,
    StDrain
  } state_e;

  state_e      state_q, state_d;
  logic        id_q, id_d;
  logic [31:0] meth_q, meth_d;
  logic [31:0] v_q, v_d;
  logic [15:0] remain_q, remain_d;
  logic [7:0]  err_q, err_d;

  logic [15:0] hdr_id;
  logic [15:0] hdr_len;
  logic        hdr_ok;
  logic        accept;
  logic        disp_fire;

  assign hdr_id  = pipe_enq_v_i[31:16];
  assign hdr_len = pipe_enq_v_i[15:0];
  assign hdr_ok  = (hdr_id < 16'd2) && (hdr_len == 16'd3);
  assign accept  = pipe_enq_ena_i && pipe_enq_rdy_o;

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StHdr;
      id_q     <= 1'b0;
      meth_q   <= '0;
      v_q      <= '0;
      remain_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      meth_q   <= meth_d;
      v_q      <= v_d;
      remain_q <= remain_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHdr: begin
        if (accept) begin
          if (hdr_ok) begin
            state_d = StArg0;
          end else if (hdr_len > 16'd1) begin
            state_d = StDrain;
          end
        end
      end
      StArg0:     if (accept) state_d = StArg1;
      StArg1:     if (accept) state_d = StDispatch;
      StDispatch: if (disp_fire) state_d = StHdr;
      StDrain:    if (accept && (remain_q == 16'd1)) state_d = StHdr;
      default:    state_d = StHdr;
    endcase
  end

  always_comb begin
    id_d     = id_q;
    meth_d   = meth_q;
    v_d      = v_q;
    remain_d = remain_q;
    err_d    = err_q;
    if (accept) begin
      unique case (state_q)
        StHdr: begin
          // id only matters for well-formed frames, where it is 0 or 1
          id_d = pipe_enq_v_i[16];
          if (!hdr_ok) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (hdr_len > 16'd1) remain_d = hdr_len - 16'd1;
          end
        end
        StArg0:  meth_d   = pipe_enq_v_i;
        StArg1:  v_d      = pipe_enq_v_i;
        StDrain: remain_d = remain_q - 16'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    pipe_enq_rdy_o  = (state_q != StDispatch);
    req_say_ena_o   = (state_q == StDispatch) && !id_q && req_say_rdy_i;
    req_say2_ena_o  = (state_q == StDispatch) && id_q && req_say2_rdy_i;
    disp_fire       = req_say_ena_o || req_say2_ena_o;
    req_say_meth_o  = meth_q;
    req_say_v_o     = v_q;
    req_say2_meth_o = meth_q;
    req_say2_v_o    = v_q;
    error_count_o   = err_q;
  end

endmodule

// File: tb/tb_echo_request_input.sv
// Directed bench for echo_request_input: frame parsing, dispatch stall, drain,
// reset mid-frame and error-count saturation.
module tb_echo_request_input;

  logic        clk;
  logic        n_rst;
  logic        pipe_ena;
  logic [31:0] pipe_v;
  logic        pipe_rdy;
  logic        say_ena, say2_ena;
  logic [31:0] say_meth, say_v, say2_meth, say2_v;
  logic        say_rdy, say2_rdy;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int say_cnt = 0;
  int say2_cnt = 0;
  int both_cnt = 0;

  echo_request_input u_dut (
    .clk_i           (clk),
    .rst_ni          (n_rst),
    .pipe_enq_ena_i  (pipe_ena),
    .pipe_enq_v_i    (pipe_v),
    .pipe_enq_rdy_o  (pipe_rdy),
    .req_say_ena_o   (say_ena),
    .req_say_meth_o  (say_meth),
    .req_say_v_o     (say_v),
    .req_say_rdy_i   (say_rdy),
    .req_say2_ena_o  (say2_ena),
    .req_say2_meth_o (say2_meth),
    .req_say2_v_o    (say2_v),
    .req_say2_rdy_i  (say2_rdy),
    .error_count_o   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count dispatches as the DUT sees them at the clock edge
  always @(posedge clk) begin
    if (say_ena) say_cnt++;
    if (say2_ena) say2_cnt++;
    if (say_ena && say2_ena) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents one word across the next rising edge
  task automatic send(input logic [31:0] w);
    check_eq("rdy_before_send", {31'd0, pipe_rdy}, 32'd1);
    pipe_ena = 1'b1;
    pipe_v   = w;
    @(negedge clk);
    pipe_ena = 1'b0;
    pipe_v   = '0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  int s0, s2;

  initial begin
    n_rst    = 1'b0;
    pipe_ena = 1'b0;
    pipe_v   = '0;
    say_rdy  = 1'b1;
    say2_rdy = 1'b1;
    @(negedge clk);
    do_reset();

    check_eq("rst_rdy", {31'd0, pipe_rdy}, 32'd1);
    check_eq("rst_say_ena", {31'd0, say_ena}, 32'd0);
    check_eq("rst_say2_ena", {31'd0, say2_ena}, 32'd0);
    check_eq("rst_meth", say_meth, 32'd0);
    check_eq("rst_v", say2_v, 32'd0);
    check_eq("rst_err", {24'd0, err_cnt}, 32'd0);

    s0 = say_cnt; s2 = say2_cnt;
    send(32'h0000_0003);
    send(32'h0000_0011);
    send(32'h0000_0022);
    check_eq("t1_say_ena", {31'd0, say_ena}, 32'd1);
    check_eq("t1_say2_ena", {31'd0, say2_ena}, 32'd0);
    check_eq("t1_meth", say_meth, 32'h11);
    check_eq("t1_v", say_v, 32'h22);
    check_eq("t1_rdy_disp", {31'd0, pipe_rdy}, 32'd0);
    @(negedge clk);
    check_eq("t1_say_ena_off", {31'd0, say_ena}, 32'd0);
    check_eq("t1_rdy_back", {31'd0, pipe_rdy}, 32'd1);
    check_eq("t1_say_cnt", say_cnt - s0, 32'd1);
    check_eq("t1_say2_cnt", say2_cnt - s2, 32'd0);
    check_eq("t1_err", {24'd0, err_cnt}, 32'd0);

    s0 = say_cnt; s2 = say2_cnt;
    say2_rdy = 1'b0;
    send(32'h0001_0003);
    send(32'h0000_000A);
    send(32'h0000_000B);
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_stall_rdy", {31'd0, pipe_rdy}, 32'd0);
      check_eq("t2_stall_ena", {30'd0, say_ena, say2_ena}, 32'd0);
      @(negedge clk);
    end
    say2_rdy = 1'b1;
    #1;
    check_eq("t2_say2_ena", {31'd0, say2_ena}, 32'd1);
    check_eq("t2_meth", say2_meth, 32'hA);
    check_eq("t2_v", say2_v, 32'hB);
    @(negedge clk);
    check_eq("t2_rdy_back", {31'd0, pipe_rdy}, 32'd1);
    check_eq("t2_say2_cnt", say2_cnt - s2, 32'd1);
    check_eq("t2_say_cnt", say_cnt - s0, 32'd0);

    s0 = say_cnt; s2 = say2_cnt;
    send(32'h0005_0004);
    check_eq("t3_err_next", {24'd0, err_cnt}, 32'd1);
    send(32'h0000_0003);
    send(32'h0001_0003);
    send(32'h0000_0003);
    check_eq("t3_no_ena", (say_cnt - s0) + (say2_cnt - s2), 32'd0);
    send(32'h0000_0003);
    send(32'h0000_0033);
    send(32'h0000_0044);
    check_eq("t3_say_ena", {31'd0, say_ena}, 32'd1);
    check_eq("t3_meth", say_meth, 32'h33);
    check_eq("t3_v", say_v, 32'h44);
    @(negedge clk);
    check_eq("t3_say_cnt", say_cnt - s0, 32'd1);
    check_eq("t3_err", {24'd0, err_cnt}, 32'd1);

    do_reset();
    s0 = say_cnt; s2 = say2_cnt;
    send(32'h0000_0001);
    send(32'h0000_0000);
    check_eq("t4_err", {24'd0, err_cnt}, 32'd2);
    send(32'h0001_0003);
    send(32'h1234_5678);
    send(32'h9ABC_DEF0);
    check_eq("t4_say2_ena", {31'd0, say2_ena}, 32'd1);
    check_eq("t4_meth", say2_meth, 32'h1234_5678);
    check_eq("t4_v", say2_v, 32'h9ABC_DEF0);
    @(negedge clk);
    check_eq("t4_say2_cnt", say2_cnt - s2, 32'd1);
    check_eq("t4_say_cnt", say_cnt - s0, 32'd0);

    s0 = say_cnt; s2 = say2_cnt;
    send(32'h0000_0003);
    send(32'h0000_0055);
    do_reset();
    check_eq("t5_rdy", {31'd0, pipe_rdy}, 32'd1);
    check_eq("t5_meth_clr", say_meth, 32'd0);
    check_eq("t5_err", {24'd0, err_cnt}, 32'd0);
    send(32'h0000_0003);
    send(32'h0000_0066);
    send(32'h0000_0077);
    check_eq("t5_say_ena", {31'd0, say_ena}, 32'd1);
    check_eq("t5_meth", say_meth, 32'h66);
    check_eq("t5_v", say_v, 32'h77);
    @(negedge clk);
    check_eq("t5_say_cnt", say_cnt - s0, 32'd1);
    check_eq("t5_err_after", {24'd0, err_cnt}, 32'd0);

    do_reset();
    for (int i = 1; i <= 256; i++) begin
      pipe_ena = 1'b1;
      pipe_v   = 32'h0002_0001;
      @(negedge clk);
      pipe_ena = 1'b0;
      if (i == 1) check_eq("t6_err_1", {24'd0, err_cnt}, 32'd1);
      if (i == 254) check_eq("t6_err_254", {24'd0, err_cnt}, 32'd254);
      if (i == 255) check_eq("t6_err_255", {24'd0, err_cnt}, 32'd255);
    end
    check_eq("t6_err_sat", {24'd0, err_cnt}, 32'd255);
    check_eq("t6_rdy", {31'd0, pipe_rdy}, 32'd1);

    check_eq("never_both_ena", both_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
